// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared types for the sequential multiplier.
// FSM state, Booth digit and cycle-count helper (SEQ_MULT_BOOTH_EN aware).
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        BD_ZERO,
        BD_P1,
        BD_P2,
        BD_M1,
        BD_M2
    } booth_t;

    // Number of BUSY cycles for a given operand width.
    function automatic int steps(input int width);
`ifdef SEQ_MULT_BOOTH_EN
        return width / 2;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/seq_multiplier_booth_r4_enc.sv
// booth_r4_enc: radix-4 Booth recoder for one 3-bit multiplier window.
// Ports: win (window), mcand (extended multiplicand), digit, pp (partial product).
module booth_r4_enc
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       win,
    input  logic [WIDTH:0]   mcand,
    output booth_t           digit,
    output logic [WIDTH+2:0] pp
);

    logic [WIDTH+2:0] m1;
    logic [WIDTH+2:0] m2;

    assign m1 = {{2{mcand[WIDTH]}}, mcand};
    assign m2 = {m1[WIDTH+1:0], 1'b0};

    always_comb begin
        digit = BD_ZERO;
        unique case (win)
            3'b001, 3'b010: digit = BD_P1;
            3'b011:         digit = BD_P2;
            3'b100:         digit = BD_M2;
            3'b101, 3'b110: digit = BD_M1;
            default:        digit = BD_ZERO;
        endcase
    end

    always_comb begin
        pp = '0;
        unique case (digit)
            BD_P1:   pp = m1;
            BD_P2:   pp = m2;
            BD_M1:   pp = -m1;
            BD_M2:   pp = -m2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: multi-cycle signed/unsigned multiplier, 2*WIDTH result.
// Ports: clk, rst (async high), mult_begin/mult_signed/mult_op1/mult_op2 in;
// product, mult_end, mult_busy out. SEQ_MULT_BOOTH_EN selects radix-4 Booth.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mult_begin,
    input  logic               mult_signed,
    input  logic [WIDTH-1:0]   mult_op1,
    input  logic [WIDTH-1:0]   mult_op2,
    output logic [2*WIDTH-1:0] product,
    output logic               mult_end,
    output logic               mult_busy
);

    localparam int N  = steps(WIDTH);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               begin_q;
    logic               start;
    logic               last;
    logic [WIDTH-1:0]   a_r;
    logic               sgn_r;
    logic [2*WIDTH-1:0] res;

    // A held level never restarts; only a sampled 0->1 transition does.
    assign start = mult_begin & ~begin_q & (state != BUSY);
    assign last  = (cnt == CW'(N - 1));

`ifdef SEQ_MULT_BOOTH_EN
    localparam int AW = 2 * WIDTH + 3;

    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_nxt;
    logic             prev;
    logic             b_msb;
    logic [WIDTH:0]   a_x;
    booth_t           digit;
    logic [WIDTH+2:0] pp;
    logic [WIDTH+2:0] sum;

    assign a_x = {sgn_r & a_r[WIDTH-1], a_r};

    booth_r4_enc #(
        .WIDTH(WIDTH)
    ) u_enc (
        .win  ({acc[1:0], prev}),
        .mcand(a_x),
        .digit(digit),
        .pp   (pp)
    );

    assign sum     = acc[AW-1:WIDTH] + ((digit == BD_ZERO) ? '0 : pp);
    assign acc_nxt = {{2{sum[WIDTH+2]}}, sum, acc[WIDTH-1:2]};

    // Booth treats op2 as signed; an unsigned op2 with MSB set needs +op1<<W.
    assign res = acc_nxt[2*WIDTH-1:0]
               + ((~sgn_r & b_msb) ? {a_r, {WIDTH{1'b0}}} : '0);

    always_ff @(posedge clk) begin
        if (start) begin
            acc   <= {{(WIDTH + 3){1'b0}}, mult_op2};
            prev  <= 1'b0;
            a_r   <= mult_op1;
            sgn_r <= mult_signed;
            b_msb <= mult_op2[WIDTH-1];
        end else if (state == BUSY) begin
            acc  <= acc_nxt;
            prev <= acc[1];
        end
    end
`else
    localparam int AW = 2 * WIDTH + 1;

    logic [AW-1:0]      acc;
    logic [AW-1:0]      acc_nxt;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] fix_a;
    logic [2*WIDTH-1:0] fix_b;

    assign sum     = acc[AW-1:WIDTH]
                   + {1'b0, (acc[0] ? a_r : {WIDTH{1'b0}})};
    assign acc_nxt = {1'b0, sum, acc[WIDTH-1:1]};

    // Unsigned product minus the weight of each negative operand's sign bit.
    assign fix_a = (sgn_r & a_r[WIDTH-1]) ? {b_r, {WIDTH{1'b0}}} : '0;
    assign fix_b = (sgn_r & b_r[WIDTH-1]) ? {a_r, {WIDTH{1'b0}}} : '0;
    assign res   = acc_nxt[2*WIDTH-1:0] - fix_a - fix_b;

    always_ff @(posedge clk) begin
        if (start) begin
            acc   <= {{(WIDTH + 1){1'b0}}, mult_op2};
            a_r   <= mult_op1;
            b_r   <= mult_op2;
            sgn_r <= mult_signed;
        end else if (state == BUSY) begin
            acc <= acc_nxt;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            begin_q   <= 1'b0;
            product   <= '0;
            mult_end  <= 1'b0;
            mult_busy <= 1'b0;
        end else begin
            begin_q  <= mult_begin;
            mult_end <= 1'b0;
            unique case (state)
                BUSY: begin
                    if (!mult_begin) begin
                        state     <= IDLE;
                        mult_busy <= 1'b0;
                    end else if (last) begin
                        state     <= DONE;
                        product   <= res;
                        mult_end  <= 1'b1;
                        mult_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (start) begin
                        state     <= BUSY;
                        cnt       <= '0;
                        mult_busy <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        mult_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random checks of seq_multiplier, WIDTH=32.
// Honours SEQ_MULT_BOOTH_EN for the expected latency.
module tb_seq_multiplier;

    localparam int W = 32;
`ifdef SEQ_MULT_BOOTH_EN
    localparam int N = W / 2;
`else
    localparam int N = W;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           mult_begin;
    logic           mult_signed;
    logic [W-1:0]   mult_op1;
    logic [W-1:0]   mult_op2;
    logic [2*W-1:0] product;
    logic           mult_end;
    logic           mult_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_multiplier #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mult_begin (mult_begin),
        .mult_signed(mult_signed),
        .mult_op1   (mult_op1),
        .mult_op2   (mult_op2),
        .product    (product),
        .mult_end   (mult_end),
        .mult_busy  (mult_busy)
    );

    task automatic check(input string tag, input logic [2*W-1:0] got,
                         input logic [2*W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: extend each operand to 2W bits per mode, multiply, truncate.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic s);
        logic signed [2*W-1:0] x;
        logic signed [2*W-1:0] y;
        x = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        y = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return x * y;
    endfunction

    // Waits up to N+4 edges after the capture edge for mult_end.
    task automatic wait_done(input string tag, input logic [2*W-1:0] exp);
        int lat;
        lat = 0;
        for (int k = 1; k <= N + 4; k++) begin
            @(posedge clk);
            #1;
            if (mult_end) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, N);
        check({tag, "_prod"}, product, exp);
        check({tag, "_busy_off"}, mult_busy, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_end_pulse"}, mult_end, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic s,
                          input logic [2*W-1:0] exp);
        @(negedge clk);
        mult_begin = 1'b0;
        @(negedge clk);
        mult_op1    = a;
        mult_op2    = b;
        mult_signed = s;
        mult_begin  = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy_on"}, mult_busy, 1'b1);
        // Inputs are scrambled after capture; the result must not change.
        @(negedge clk);
        mult_op1    = $urandom;
        mult_op2    = $urandom;
        mult_signed = 1'($urandom);
        wait_done(tag, exp);
    endtask

    initial begin
        int          ends;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] corner [5];

        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'hFFFF_FFFF;
        corner[4] = 32'h7FFF_FFFF;

        rst         = 1'b0;
        mult_begin  = 1'b0;
        mult_signed = 1'b0;
        mult_op1    = '0;
        mult_op2    = '0;
        #2;
        rst = 1'b1;
        #1;
        check("rst0_prod", product, '0);
        check("rst0_end", mult_end, 1'b0);
        check("rst0_busy", mult_busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("u1111", 32'h1111, 32'h1111, 1'b0, 64'h0000_0000_0123_4321);
        run_op("u2222", 32'h1111, 32'h2222, 1'b0, 64'h0000_0000_0246_8642);
        run_op("s_m1", 32'h2, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("u_m1", 32'h2, 32'hFFFF_FFFF, 1'b0, 64'h0000_0001_FFFF_FFFE);
        run_op("s_minxm", 32'h8000_0000, 32'h8000_0000, 1'b1,
               64'h4000_0000_0000_0000);
        run_op("u_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
               64'hFFFF_FFFE_0000_0001);
        run_op("s_min", 32'h2, 32'h8000_0000, 1'b1, 64'hFFFF_FFFF_0000_0000);
        run_op("u_min", 32'h2, 32'h8000_0000, 1'b0, 64'h0000_0001_0000_0000);

        // Abort: begin dropped before the 5th BUSY edge.
        @(negedge clk);
        mult_begin = 1'b0;
        @(negedge clk);
        mult_op1    = 32'h1111;
        mult_op2    = 32'h1111;
        mult_signed = 1'b0;
        mult_begin  = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        mult_begin = 1'b0;
        ends = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mult_end) ends++;
        end
        check("abort_end", ends, 0);
        check("abort_prod", product, 64'h0000_0001_0000_0000);
        check("abort_busy", mult_busy, 1'b0);

        // Hold begin high for 40 cycles: exactly one completion.
        @(negedge clk);
        mult_op1    = 32'h1111;
        mult_op2    = 32'h2222;
        mult_signed = 1'b0;
        mult_begin  = 1'b1;
        ends = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mult_end) ends++;
        end
        check("hold_end", ends, 1);
        check("hold_prod", product, 64'h0000_0000_0246_8642);

        // Async reset mid-BUSY, then begin already high restarts.
        @(negedge clk);
        mult_begin = 1'b0;
        @(negedge clk);
        mult_op1    = 32'h1111;
        mult_op2    = 32'h1111;
        mult_signed = 1'b0;
        mult_begin  = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_prod", product, '0);
        check("rst_busy", mult_busy, 1'b0);
        check("rst_end", mult_end, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_restart_busy", mult_busy, 1'b1);
        wait_done("rst_restart", 64'h0000_0000_0123_4321);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            if ($urandom_range(0, 7) == 0) a = corner[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) b = corner[$urandom_range(0, 4)];
            run_op("rand", a, b, s, model(a, b, s));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
